uart_tx_fifo_engine: RTL and testbench

//   Parametrised next-generation UART transmit engine with integrated FIFO and
//   own bit-rate divider. Adds 5-8 data bits, 1/2 stop bits, break generation,

---
 rtl/uart_tx_fifo_engine.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_engine
//   UART transmit engine with an integrated byte FIFO and its own bit-rate
//   divider. Supports 5-8 data bits, optional odd/even parity, one or two
//   stop bits and break generation. It also reports the FIFO fill level and
//   flags writes made while the FIFO is full (sticky overflow).
//
// Ports
//   CLK, RESET_N   clock (rising edge) and synchronous active-low reset
//   WEN, DATA_IN   byte push into the FIFO
//   BAUD_VAL       bit period = BAUD_VAL+1 clock cycles
//   DATA_BITS      00=5, 01=6, 10=7, 11=8 data bits
//   PARITY_EN      append a parity bit
//   ODD_N_EVEN     1 = odd parity, 0 = even parity
//   STOP2          1 = two stop bits, 0 = one stop bit
//   BREAK          hold TX low once the engine is idle
//   FIFO_CLR       flush the queued bytes; a frame in flight still completes
//   CLR_OVF        clear OVERFLOW
//   TX             serial line, idle high, registered
//   TXRDY          FIFO not full
//   TX_EMPTY       FIFO empty and engine idle
//   FIFO_LEVEL     number of queued bytes, 0..2**FIFO_AW
//   OVERFLOW       sticky flag: a write was attempted while the FIFO was full
//   DBG_STATE      current FSM state encoding, for observation only
//
// Handshake: WEN is a one-cycle push strobe with no back-pressure. A byte is
//   accepted when TXRDY is high, or when the FIFO is full and the engine pops
//   in the same cycle. Any other write while full is dropped and OVERFLOW is
//   set.
// -----------------------------------------------------------------------------
module uart_tx_fifo_engine #(
   parameter int FIFO_AW = 4,
   parameter int BAUD_W  = 16
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               WEN,
   input  logic [7:0]         DATA_IN,
   input  logic [BAUD_W-1:0]  BAUD_VAL,
   input  logic [1:0]         DATA_BITS,
   input  logic               PARITY_EN,
   input  logic               ODD_N_EVEN,
   input  logic               STOP2,
   input  logic               BREAK,
   input  logic               FIFO_CLR,
   input  logic               CLR_OVF,
   output logic               TX,
   output logic               TXRDY,
   output logic               TX_EMPTY,
   output logic [FIFO_AW:0]   FIFO_LEVEL,
   output logic               OVERFLOW,
   output logic [2:0]         DBG_STATE
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]  LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [BAUD_W-1:0] CNT_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } state_t;

   // FSM / shifter state
   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   cnt_q, cnt_d;        // cycles left in the current bit
   logic [BAUD_W-1:0]   baud_q, baud_d;      // bit period latched at pop
   logic [7:0]          shift_q, shift_d;
   logic [2:0]          nbits_q, nbits_d;    // data bits left after the current one
   logic                par_en_q, par_en_d;
   logic                par_q, par_d;
   logic                stop2_q, stop2_d;
   logic                stop_more_q, stop_more_d; // a second stop bit follows
   logic                mark_hold_q, mark_hold_d; // post-break mark period running
   logic                tx_q, tx_d;

   // FIFO state
   logic [7:0]          mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]    level_q, level_d;
   logic                ovf_q, ovf_d;

   logic                fifo_empty, fifo_full;
   logic                pop, push, bit_end;
   logic [7:0]          head, data_mask;
   logic                head_par;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_FULL);
   assign bit_end    = (cnt_q == '0);
   assign head       = mem_q[rd_ptr_q];

   // Parity of the byte about to be popped, restricted to the configured
   // width so that unused MSBs never influence the parity bit.
   always_comb begin
      data_mask = 8'hFF;
      case (DATA_BITS)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      head_par = (^(head & data_mask)) ^ ODD_N_EVEN;
   end

   // Frame sequencer. tx_d always carries the line level of the bit that the
   // next state will present, so TX is a plain flop with no decode glitches.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      baud_d      = baud_q;
      shift_d     = shift_q;
      nbits_d     = nbits_q;
      par_en_d    = par_en_q;
      par_d       = par_q;
      stop2_d     = stop2_q;
      stop_more_d = stop_more_q;
      mark_hold_d = mark_hold_q;
      tx_d        = tx_q;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (mark_hold_q && !bit_end) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               mark_hold_d = 1'b0;
               if (BREAK) begin
                  state_d = ST_BRK;
                  tx_d    = 1'b0;
               end else if (!fifo_empty) begin
                  pop = 1'b1;
               end
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
               cnt_d   = baud_q;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d = baud_q;
               if (nbits_q != 3'd0) begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  nbits_d = nbits_q - 3'd1;
               end else if (par_en_q) begin
                  state_d = ST_PARITY;
                  tx_d    = par_q;
               end else begin
                  state_d     = ST_STOP;
                  tx_d        = 1'b1;
                  stop_more_d = stop2_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d     = ST_STOP;
               tx_d        = 1'b1;
               stop_more_d = stop2_q;
               cnt_d       = baud_q;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (stop_more_q) begin
                  stop_more_d = 1'b0;
                  cnt_d       = baud_q;
               end else if (!fifo_empty && !BREAK) begin
                  pop = 1'b1;   // back-to-back: next start bit follows directly
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_BRK: begin
            tx_d = 1'b0;
            if (!BREAK) begin
               // Guarantee one full bit period of mark before any new start bit.
               state_d     = ST_IDLE;
               tx_d        = 1'b1;
               mark_hold_d = 1'b1;
               cnt_d       = BAUD_VAL;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A pop snapshots the byte and the whole frame format, so later
      // configuration changes cannot disturb the frame in flight.
      if (pop) begin
         state_d  = ST_START;
         tx_d     = 1'b0;
         cnt_d    = BAUD_VAL;
         baud_d   = BAUD_VAL;
         shift_d  = head;
         nbits_d  = 3'd4 + {1'b0, DATA_BITS};
         par_en_d = PARITY_EN;
         par_d    = head_par;
         stop2_d  = STOP2;
      end
   end

   // FIFO bookkeeping. A pop frees a slot in the same cycle, so a write to
   // a full FIFO is still accepted when it coincides with a pop.
   always_comb begin
      push     = WEN && (!fifo_full || pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;

      if (FIFO_CLR) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end

      // Setting wins over clearing in the same cycle.
      if (WEN && fifo_full && !pop) ovf_d = 1'b1;
      else if (CLR_OVF)             ovf_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         baud_q      <= '0;
         shift_q     <= '0;
         nbits_q     <= '0;
         par_en_q    <= 1'b0;
         par_q       <= 1'b0;
         stop2_q     <= 1'b0;
         stop_more_q <= 1'b0;
         mark_hold_q <= 1'b0;
         tx_q        <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         baud_q      <= baud_d;
         shift_q     <= shift_d;
         nbits_q     <= nbits_d;
         par_en_q    <= par_en_d;
         par_q       <= par_d;
         stop2_q     <= stop2_d;
         stop_more_q <= stop_more_d;
         mark_hold_q <= mark_hold_d;
         tx_q        <= tx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= DATA_IN;
   end

   assign TX         = tx_q;
   assign TXRDY      = !fifo_full;
   assign TX_EMPTY   = fifo_empty && (state_q == ST_IDLE);
   assign FIFO_LEVEL = level_q;
   assign OVERFLOW   = ovf_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
module tb_uart_tx_fifo_engine;

   logic        clk;
   logic        reset_n;
   logic        wen;
   logic [7:0]  data_in;
   logic [15:0] baud_val;
   logic [1:0]  data_bits;
   logic        parity_en;
   logic        odd_n_even;
   logic        stop2;
   logic        brk;
   logic        fifo_clr;
   logic        clr_ovf;
   logic        tx;
   logic        txrdy;
   logic        tx_empty;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_fifo_engine #(.FIFO_AW(2), .BAUD_W(16)) dut (
      .CLK        (clk),
      .RESET_N    (reset_n),
      .WEN        (wen),
      .DATA_IN    (data_in),
      .BAUD_VAL   (baud_val),
      .DATA_BITS  (data_bits),
      .PARITY_EN  (parity_en),
      .ODD_N_EVEN (odd_n_even),
      .STOP2      (stop2),
      .BREAK      (brk),
      .FIFO_CLR   (fifo_clr),
      .CLR_OVF    (clr_ovf),
      .TX         (tx),
      .TXRDY      (txrdy),
      .TX_EMPTY   (tx_empty),
      .FIFO_LEVEL (fifo_level),
      .OVERFLOW   (overflow),
      .DBG_STATE  (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   // Sample TX at n consecutive falling edges, first sample taken now.
   task automatic capture(input int n, output logic [63:0] bits);
      bits = '0;
      for (int i = 0; i < n; i++) begin
         bits[i] = tx;
         tick();
      end
   endtask

   // Reference line waveform of one frame, one entry per clock cycle.
   function automatic logic [63:0] frame_bits(input logic [7:0] d, input int nb,
                                              input bit pen, input bit odd,
                                              input bit s2, input int bp);
      logic [63:0] v;
      logic        b [12];
      int          m;
      logic        p;
      v = '0;
      m = 0;
      p = odd;
      b[m] = 1'b0; m++;
      for (int j = 0; j < nb; j++) begin
         b[m] = d[j]; p = p ^ d[j]; m++;
      end
      if (pen) begin b[m] = p; m++; end
      b[m] = 1'b1; m++;
      if (s2) begin b[m] = 1'b1; m++; end
      for (int j = 0; j < m; j++)
         for (int c = 0; c < bp; c++)
            v[j*bp+c] = b[j];
      return v;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0; tick(); tick();
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_checks++; if (txrdy !== 1'b1) begin n_fail++; $display("FAIL reset_txrdy: got %b expected 1", txrdy); end
      n_checks++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_tx_empty: got %b expected 1", tx_empty); end
      n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      reset_n = 1'b1; tick();
   endtask

   task automatic test_frame();
      logic [63:0] bits, exp;
      logic [9:0]  mid;
      baud_val = 16'd3; data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b0;
      wen = 1'b1; data_in = 8'hA5; tick();
      wen = 1'b0;
      n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL frame_level_n1: got %0d expected 1", fifo_level); end
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_tx_n1: got %b expected 1", tx); end
      tick();
      n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL frame_start_n2: got %b expected 0", tx); end
      n_checks++; if (tx_empty !== 1'b0) begin n_fail++; $display("FAIL frame_busy: got %b expected 0", tx_empty); end
      capture(40, bits);
      exp = frame_bits(8'hA5, 8, 1'b0, 1'b0, 1'b0, 4);
      n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL frame_a5_wave: got %h expected %h", bits, exp); end
      for (int k = 0; k < 10; k++) mid[k] = bits[4*k+1];
      n_checks++; if (mid !== 10'b1101001010) begin n_fail++; $display("FAIL frame_a5_bits: got %b expected 1101001010", mid); end
      n_checks++; if (tx_empty !== 1'b1 || tx !== 1'b1) begin n_fail++; $display("FAIL frame_done: got empty=%b tx=%b expected 1 1", tx_empty, tx); end
   endtask

   task automatic test_format();
      logic [63:0] bits, exp;
      baud_val = 16'd3; data_bits = 2'b00; parity_en = 1'b1; odd_n_even = 1'b1; stop2 = 1'b1;
      wen = 1'b1; data_in = 8'hFF; tick();
      wen = 1'b0; tick();
      // Frame started with the latched format; change everything now.
      data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b0; baud_val = 16'd0;
      capture(36, bits);
      exp = frame_bits(8'hFF, 5, 1'b1, 1'b1, 1'b1, 4);
      n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL fmt_5o2_wave: got %h expected %h", bits, exp); end
      n_checks++; if (bits[23:4] !== 20'hFFFFF) begin n_fail++; $display("FAIL fmt_data_ones: got %h expected fffff", bits[23:4]); end
      n_checks++; if (bits[27:24] !== 4'h0) begin n_fail++; $display("FAIL fmt_parity: got %h expected 0", bits[27:24]); end
      n_checks++; if (bits[35:28] !== 8'hFF || tx_empty !== 1'b1) begin n_fail++; $display("FAIL fmt_stop2: got %h empty=%b expected ff 1", bits[35:28], tx_empty); end
      // One cycle per bit.
      wen = 1'b1; data_in = 8'h3C; tick();
      wen = 1'b0; tick();
      capture(10, bits);
      exp = frame_bits(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
      n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL fmt_baud0_wave: got %h expected %h", bits, exp); end
      n_checks++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL fmt_baud0_done: got %b expected 1", tx_empty); end
   endtask

   task automatic test_overflow();
      baud_val = 16'd1; data_bits = 2'b11; parity_en = 1'b1; odd_n_even = 1'b0; stop2 = 1'b0;
      brk = 1'b1; tick();
      n_checks++; if (tx !== 1'b0 || tx_empty !== 1'b0) begin n_fail++; $display("FAIL brk_idle: got tx=%b empty=%b expected 0 0", tx, tx_empty); end
      for (int i = 0; i < 5; i++) begin
         wen = 1'b1; data_in = 8'h10 + 8'(i); tick();
      end
      wen = 1'b0;
      n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
      n_checks++; if (txrdy !== 1'b0) begin n_fail++; $display("FAIL ovf_txrdy: got %b expected 0", txrdy); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      wen = 1'b1; data_in = 8'hEE; clr_ovf = 1'b1; tick();
      wen = 1'b0; clr_ovf = 1'b0;
      n_checks++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_priority: got ovf=%b lvl=%0d expected 1 4", overflow, fifo_level); end
      clr_ovf = 1'b1; tick();
      clr_ovf = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] bits, exp;
      logic [7:0]  seq [5];
      seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12; seq[3] = 8'h13; seq[4] = 8'h5A;
      brk = 1'b0; tick();
      n_checks++; if (tx !== 1'b1 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_mark1: got tx=%b lvl=%0d expected 1 4", tx, fifo_level); end
      tick();
      n_checks++; if (tx !== 1'b1 || txrdy !== 1'b0) begin n_fail++; $display("FAIL b2b_mark2: got tx=%b rdy=%b expected 1 0", tx, txrdy); end
      wen = 1'b1; data_in = 8'h5A; tick();
      wen = 1'b0;
      n_checks++; if (fifo_level !== 3'd4 || tx !== 1'b0) begin n_fail++; $display("FAIL b2b_push_pop: got lvl=%0d tx=%b expected 4 0", fifo_level, tx); end
      for (int f = 0; f < 5; f++) begin
         capture(22, bits);
         exp = frame_bits(seq[f], 8, 1'b1, 1'b0, 1'b0, 2);
         n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL b2b_frame%0d: got %h expected %h", f, bits, exp); end
      end
      n_checks++; if (tx_empty !== 1'b1 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got empty=%b lvl=%0d expected 1 0", tx_empty, fifo_level); end
   endtask

   task automatic test_break_flush();
      logic [63:0] bits, exp;
      int lows;
      baud_val = 16'd1; data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b0;
      wen = 1'b1; data_in = 8'h55; tick();
      wen = 1'b0; tick();
      bits = '0;
      for (int i = 0; i < 20; i++) begin
         bits[i] = tx;
         if (i >= 2 && i <= 4) begin wen = 1'b1; data_in = 8'h7F + 8'(i); end
         if (i == 5) wen = 1'b0;
         if (i == 6) brk = 1'b1;
         if (i == 8) begin
            n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d expected 3", fifo_level); end
            fifo_clr = 1'b1;
         end
         if (i == 9) begin
            fifo_clr = 1'b0;
            n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", fifo_level); end
         end
         tick();
      end
      exp = frame_bits(8'h55, 8, 1'b0, 1'b0, 1'b0, 2);
      n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL brk_inflight: got %h expected %h", bits, exp); end
      tick();
      n_checks++; if (tx !== 1'b0 || tx_empty !== 1'b0) begin n_fail++; $display("FAIL brk_low: got tx=%b empty=%b expected 0 0", tx, tx_empty); end
      lows = 0;
      for (int i = 0; i < 6; i++) begin
         if (tx === 1'b0) lows++;
         tick();
      end
      n_checks++; if (lows !== 6) begin n_fail++; $display("FAIL brk_hold: got %0d low cycles expected 6", lows); end
      brk = 1'b0; tick();
      n_checks++; if (tx !== 1'b1 || tx_empty !== 1'b1) begin n_fail++; $display("FAIL brk_release: got tx=%b empty=%b expected 1 1", tx, tx_empty); end
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         if (tx !== 1'b1) lows++;
         tick();
      end
      n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL flush_nothing_sent: got %0d non-mark cycles expected 0", lows); end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      baud_val = 16'd3; data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wen = 1'b1; data_in = (i == 0) ? 8'h00 : 8'hC0 + 8'(i); tick();
      end
      wen = 1'b0;
      n_checks++; if (tx !== 1'b0 || fifo_level !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got tx=%b lvl=%0d ovf=%b expected 0 4 1", tx, fifo_level, overflow); end
      reset_n = 1'b0; tick();
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
      n_checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fifo: got lvl=%0d ovf=%b expected 0 0", fifo_level, overflow); end
      n_checks++; if (txrdy !== 1'b1 || tx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: got rdy=%b empty=%b expected 1 1", txrdy, tx_empty); end
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (tx !== 1'b1) bad++;
         tick();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_residual: got %0d non-mark cycles expected 0", bad); end
   endtask

   initial begin
      reset_n = 1'b0; wen = 1'b0; data_in = 8'h00; baud_val = 16'd3;
      data_bits = 2'b11; parity_en = 1'b0; odd_n_even = 1'b0; stop2 = 1'b0;
      brk = 1'b0; fifo_clr = 1'b0; clr_ovf = 1'b0;
      test_reset();
      test_frame();
      test_format();
      test_overflow();
      test_back_to_back();
      test_break_flush();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
